cs_resolver: RTL and testbench
==============================

# cs_resolver

Iterative carry-propagate stage for the compressor-based multiplier. It accepts the two redundant rows (sum, carry) produced by the 4-2 compressor tree over a valid/ready handshake. It resolves them into a single binary word by adding CHUNK bits per clock, then presents the result and carry-out on a valid/ready output. It sits between the compressor tree and any downstream consumer of the product.

## Interface
- W, 16: width of each input row and of the result; must be a multiple of CHUNK.
- CHUNK, 4: bits resolved per ADD cycle; N = W/CHUNK ADD cycles per operation.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream offers a row pair.
- in_ready  out  1  block can accept a row pair.
- in_sum  in  W  sum row.
- in_carry  in  W  carry row, already aligned to the weight of in_sum by the upstream stage (no internal shift).
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_data  out  W  (in_sum + in_carry) mod 2^W.
- out_ovf  out  1  carry out of bit W-1.

## Operation
- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, latch in_sum and in_carry, clear chunk index idx and running carry c, then go to ADD.
- ADD:
  - in_ready=0.
  - Each cycle, add chunk idx of both rows plus c using a CHUNK-bit ripple adder.
  - Write the result into bits [idx*CHUNK +: CHUNK] of the result register, update c with the chunk carry-out, and increment idx.
  - After chunk N-1 is processed, latch out_ovf=c and go to DONE.
- DONE:
  - out_valid=1; out_data and out_ovf are held stable.
  - On out_valid && out_ready, go to IDLE.
- While not in IDLE, in_valid is ignored. No operation is ever dropped or overwritten.
- Arithmetic is unsigned modulo 2^W. The carry between chunks must be exact: a full-width ripple such as 0xFFFF+0x0001 propagates through every chunk.
- out_data bits of chunks not yet resolved are don't-care internally but are never visible, because out_valid=0 outside DONE.
- Reset at any time, including mid-ADD or in DONE with out_ready low:
  - Next state is IDLE; idx=0, c=0.
  - out_data=0, out_ovf=0, out_valid=0, in_ready=1 from the cycle after the reset edge.
  - A partial result is discarded.
- Reset values of all outputs: in_ready=1, out_valid=0, out_data=0, out_ovf=0.

## Timing
- Accept handshake at edge t: ADD occupies the cycles after t, chunk 0 is processed at edge t+1, and chunk N-1 at edge t+N.
- out_valid rises in the cycle following edge t+N, i.e. N cycles of latency from accept to valid (4 for the defaults).
- Output handshake at edge u: in_ready=1 from edge u. The earliest next accept is at edge u+1, giving a minimum period of N+2 cycles per operation.
- in_ready and out_valid are registered state decodes. They have no combinational path from in_valid or out_ready.
- Simultaneous rst and a handshake: rst wins, and the handshake has no effect.

## Structure
- Shared package cmp_pkg holds:
  - the state encoding (IDLE=2'd0, ADD=2'd1, DONE=2'd2);
  - the default widths W_DEF=16 and CHUNK_DEF=4;
  - a width check (W % CHUNK == 0), enforced by an elaboration-time error.
- Sub-module cpa_chunk is a parameterised CHUNK-bit ripple adder (a, b, cin -> s, cout) built from full-adder cells. It is instantiated once and reused each ADD cycle.
- Top contains the FSM, the idx counter (clog2(N) bits), the carry flop, the operand and result registers, and the output flops.

## Test plan
- Basic add, W=16, CHUNK=4: in_sum=0x1234, in_carry=0x4321, out_ready=1 -> out_data=0x5555, out_ovf=0; out_valid exactly 4 cycles after accept; in_ready=1 in the cycle after the output handshake.
- Inter-chunk carry: 0x00FF + 0x0001 -> 0x0100, ovf=0. Full ripple: 0xFFFF + 0x0001 -> 0x0000, ovf=1. Max: 0xFFFF + 0xFFFF -> 0xFFFE, ovf=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_data and ovf stable, out_valid=1, in_ready=0. A new in_valid with 0xAAAA/0x5555 during this time is not accepted; it is accepted only after the drain and yields 0xFFFF, ovf=0.
- Reset mid-ADD (after chunk 1) with operands 0xFFFF/0x0001 -> next cycle out_valid=0, in_ready=1, out_data=0, ovf=0. A following op 0x0003 + 0x0004 gives 0x0007 with no carry contamination.
- Reset in DONE with out_ready=0 -> result dropped, out_valid=0 next cycle. Reset coinciding with an in_valid handshake -> the operation is not started.
- Random: 1000 operands with random in_valid and out_ready gaps, checked against the golden model (sum+carry) mod 2^16 plus carry-out. Also check the N+2-cycle minimum period and that no result is lost or duplicated.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the compressor-based multiplier: FSM encoding,
// default widths and the width-compatibility check.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int W_DEF     = 16;
    localparam int CHUNK_DEF = 4;

    function automatic bit width_ok(input int w, input int chunk);
        return (chunk > 0) && (w >= chunk) && ((w % chunk) == 0);
    endfunction

endpackage

// File: rtl/cs_resolver_if.sv
// Row-pair in / resolved-word out handshake bundle for cs_resolver.
interface cs_resolver_if #(
    parameter int W = cmp_pkg::W_DEF
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_sum;
    logic [W-1:0] in_carry;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;

    modport master (
        output in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/cs_resolver_cpa_chunk.sv
// CHUNK-bit ripple-carry adder made of full-adder cells.
module cpa_chunk #(
    parameter int CHUNK = cmp_pkg::CHUNK_DEF
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);
    logic [CHUNK:0] cy;

    assign cy[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]    = a[i] ^ b[i] ^ cy[i];
        assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end

    assign cout = cy[CHUNK];
endmodule

// File: rtl/cs_resolver.sv
// Iterative carry-propagate resolver: folds the sum/carry rows into one
// binary word, CHUNK bits per clock, through a single reused ripple adder.
module cs_resolver
    import cmp_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input logic         clk,
    input logic         rst,
    cs_resolver_if.slave bus
);
    localparam int N     = W / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if (!width_ok(W, CHUNK)) begin : g_width_check
        $error("cs_resolver: W must be a non-zero multiple of CHUNK");
    end

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              c;
    logic [W-1:0]      sum_q;
    logic [W-1:0]      carry_q;
    logic [W-1:0]      res_q;
    logic              ovf_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  s_chunk;
    logic              cout_chunk;

    assign a_chunk = sum_q[idx*CHUNK +: CHUNK];
    assign b_chunk = carry_q[idx*CHUNK +: CHUNK];

    cpa_chunk #(.CHUNK(CHUNK)) u_cpa (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (c),
        .s    (s_chunk),
        .cout (cout_chunk)
    );

    // Operand rows are plain data and keep their value through reset;
    // everything observable at the ports is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            c           <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        sum_q      <= bus.in_sum;
                        carry_q    <= bus.in_carry;
                        idx        <= '0;
                        c          <= 1'b0;
                        in_ready_q <= 1'b0;
                        state      <= ADD;
                    end
                end
                ADD: begin
                    res_q[idx*CHUNK +: CHUNK] <= s_chunk;
                    c   <= cout_chunk;
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(N - 1)) begin
                        ovf_q       <= cout_chunk;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = res_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_cs_resolver.sv
// Bench for cs_resolver: directed vector table, multi-cycle corner
// sequences and a randomized run against an arithmetic reference.
module tb_cs_resolver;
    localparam int W   = 16;
    localparam int CH  = 4;
    localparam int N   = W / CH;
    localparam int NOPS = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cs_resolver_if #(.W(W)) bus ();

    cs_resolver #(.W(W), .CHUNK(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] s;
        logic [15:0] c;
        logic [15:0] exp_d;
        logic        exp_o;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Offer an operand pair, wait for acceptance, then count cycles to out_valid.
    task automatic run_op(input logic [15:0] s, input logic [15:0] c,
                          output logic [15:0] d, output logic o, output int lat);
        int guard;
        bus.in_sum   = s;
        bus.in_carry = c;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            step();
            guard++;
        end
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            step();
            lat++;
        end
        d = bus.out_data;
        o = bus.out_ovf;
    endtask

    vec_t vecs[7];

    initial begin
        logic [15:0] d;
        logic        o;
        int          lat;

        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_carry  = '0;
        bus.out_ready = 1'b1;

        vecs[0] = '{16'h1234, 16'h4321, 16'h5555, 1'b0};
        vecs[1] = '{16'h00FF, 16'h0001, 16'h0100, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
        vecs[6] = '{16'h0FF0, 16'h0010, 16'h1000, 1'b0};

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data", 32'(bus.out_data), 32'd0);
        check("reset out_ovf", 32'(bus.out_ovf), 32'd0);

        // Directed vectors with immediate drain
        for (int i = 0; i < 7; i++) begin
            bus.out_ready = 1'b1;
            run_op(vecs[i].s, vecs[i].c, d, o, lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(N));
            check($sformatf("vec%0d data", i), 32'(d), 32'(vecs[i].exp_d));
            check($sformatf("vec%0d ovf", i), 32'(o), 32'(vecs[i].exp_o));
            step();
            check($sformatf("vec%0d in_ready after drain", i), 32'(bus.in_ready), 32'd1);
            check($sformatf("vec%0d out_valid after drain", i), 32'(bus.out_valid), 32'd0);
        end

        // Back-pressure in DONE with a competing request
        bus.out_ready = 1'b0;
        run_op(16'h1111, 16'h2222, d, o, lat);
        check("bp first data", 32'(d), 32'h3333);
        bus.in_sum   = 16'hAAAA;
        bus.in_carry = 16'h5555;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("bp%0d out_valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp%0d in_ready", k), 32'(bus.in_ready), 32'd0);
            check($sformatf("bp%0d data stable", k), 32'(bus.out_data), 32'h3333);
            check($sformatf("bp%0d ovf stable", k), 32'(bus.out_ovf), 32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        check("bp drain in_ready", 32'(bus.in_ready), 32'd1);
        check("bp drain out_valid", 32'(bus.out_valid), 32'd0);
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            step();
            lat++;
        end
        check("bp second latency", 32'(lat), 32'(N));
        check("bp second data", 32'(bus.out_data), 32'hFFFF);
        check("bp second ovf", 32'(bus.out_ovf), 32'd0);
        step();

        // Reset after chunk 1 of a full-ripple operation
        bus.in_sum   = 16'hFFFF;
        bus.in_carry = 16'h0001;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midadd rst out_valid", 32'(bus.out_valid), 32'd0);
        check("midadd rst in_ready", 32'(bus.in_ready), 32'd1);
        check("midadd rst out_data", 32'(bus.out_data), 32'd0);
        check("midadd rst out_ovf", 32'(bus.out_ovf), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("midadd idle%0d out_valid", k), 32'(bus.out_valid), 32'd0);
        end
        run_op(16'h0003, 16'h0004, d, o, lat);
        check("post-rst latency", 32'(lat), 32'(N));
        check("post-rst data", 32'(d), 32'h0007);
        check("post-rst ovf", 32'(o), 32'd0);
        step();

        // Reset while holding a result in DONE
        bus.out_ready = 1'b0;
        run_op(16'h7777, 16'h9999, d, o, lat);
        check("done-rst pre data", 32'(d), 32'h1110);
        check("done-rst pre ovf", 32'(o), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("done-rst out_valid", 32'(bus.out_valid), 32'd0);
        check("done-rst out_data", 32'(bus.out_data), 32'd0);
        check("done-rst out_ovf", 32'(bus.out_ovf), 32'd0);
        check("done-rst in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;

        // Reset coincident with an accept handshake
        bus.in_sum   = 16'h0102;
        bus.in_carry = 16'h0304;
        bus.in_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("rst-hs%0d in_ready", k), 32'(bus.in_ready), 32'd1);
            check($sformatf("rst-hs%0d out_valid", k), 32'(bus.out_valid), 32'd0);
        end

        // Randomized traffic against the arithmetic reference
        begin
            logic [16:0] exp_q[$];
            logic [16:0] ref_v;
            logic [16:0] got_v;
            int issued = 0;
            int received = 0;
            int cyc = 0;
            int last_acc = -1000;
            bit prev_valid = 1'b0;
            bit acc;
            bit dh;

            while ((issued < NOPS || exp_q.size() != 0) && cyc < 40000) begin
                if (!bus.in_valid && issued < NOPS && $urandom_range(0, 2) == 0) begin
                    bus.in_sum   = 16'($urandom);
                    bus.in_carry = 16'($urandom);
                    bus.in_valid = 1'b1;
                end
                bus.out_ready = ($urandom_range(0, 2) != 0);
                acc   = bus.in_valid && bus.in_ready;
                dh    = bus.out_valid && bus.out_ready;
                ref_v = {1'b0, bus.in_sum} + {1'b0, bus.in_carry};
                step();
                cyc++;
                if (acc) begin
                    check("rand period", 32'(cyc - last_acc >= N + 2), 32'd1);
                    exp_q.push_back(ref_v);
                    last_acc = cyc;
                    issued++;
                    bus.in_valid = 1'b0;
                end
                if (dh) begin
                    got_v = {bus.out_ovf, bus.out_data};
                    if (exp_q.size() == 0) begin
                        check("rand duplicate result", 32'd1, 32'd0);
                    end else begin
                        // out_data still holds the drained value right after the edge
                        check("rand result", 32'(got_v), 32'(exp_q.pop_front()));
                        received++;
                    end
                end
                if (bus.out_valid && !prev_valid)
                    check("rand latency", 32'(cyc - last_acc), 32'(N));
                prev_valid = bus.out_valid;
            end
            check("rand timeout", 32'(cyc < 40000), 32'd1);
            check("rand received count", 32'(received), 32'(NOPS));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
